inst_queue: RTL and testbench

//  Fetch-to-decode instruction queue: buffers {pc, instr, fetch-exception} entries from the fetch

---
 rtl/inst_queue_pkg.sv | 18 +
 rtl/inst_queue.sv | 105 ++++++++++
 tb/tb_inst_queue.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// ============================================================================
// Module  : inst_queue_pkg
// Brief   : Shared defaults for the fetch-to-decode instruction queue.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package inst_queue_pkg;

   localparam int          c_INSTQ_DEPTH  = 8;
   localparam int          c_INSTQ_PC_W   = 32;
   localparam int          c_INSTQ_INST_W = 32;
   // sll $0,$0,0: what decode sees when the queue is empty
   localparam logic [31:0] c_NOP_WORD     = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/inst_queue.sv
// ============================================================================
// Module  : inst_queue
// Brief   : FIFO of {exc, pc, instr} between fetch and decode, flushable.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH  = c_INSTQ_DEPTH,
   parameter int PC_W   = c_INSTQ_PC_W,
   parameter int INST_W = c_INSTQ_INST_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push_valid,
   output logic                     push_ready,
   input  logic [PC_W-1:0]          push_pc,
   input  logic [INST_W-1:0]        push_instr,
   input  logic                     push_exc,
   output logic                     pop_valid,
   input  logic                     pop_ready,
   output logic [PC_W-1:0]          pop_pc,
   output logic [INST_W-1:0]        pop_instr,
   output logic                     pop_exc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int                 c_IDX_W = $clog2(DEPTH);
   localparam int                 c_PTR_W = c_IDX_W + 1;
   localparam logic [c_PTR_W-1:0] c_DEPTH = c_PTR_W'(DEPTH);

   logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;

   logic [PC_W-1:0]    pc_mem_q    [DEPTH];
   logic [INST_W-1:0]  instr_mem_q [DEPTH];
   logic               exc_mem_q   [DEPTH];

   logic               w_empty;
   logic               w_full;
   logic               w_push_fire;
   logic               w_pop_fire;
   logic [c_IDX_W-1:0] w_wr_idx;
   logic [c_IDX_W-1:0] w_rd_idx;

   assign w_wr_idx = wr_ptr_q[c_IDX_W-1:0];
   assign w_rd_idx = rd_ptr_q[c_IDX_W-1:0];
   assign w_empty  = (wr_ptr_q == rd_ptr_q);
   assign w_full   = (w_wr_idx == w_rd_idx) && (wr_ptr_q[c_IDX_W] != rd_ptr_q[c_IDX_W]);

   assign push_ready  = ~w_full;
   assign pop_valid   = ~w_empty;
   assign count       = wr_ptr_q - rd_ptr_q;
   assign w_push_fire = push_valid & push_ready & ~flush;
   assign w_pop_fire  = pop_valid & pop_ready & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q + c_PTR_W'(w_push_fire);
      rd_ptr_d = rd_ptr_q + c_PTR_W'(w_pop_fire);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is unreset; the pointers alone decide which slots are visible.
   always_ff @(posedge clk) begin
      if (w_push_fire) begin
         pc_mem_q[w_wr_idx]    <= push_pc;
         instr_mem_q[w_wr_idx] <= push_instr;
         exc_mem_q[w_wr_idx]   <= push_exc;
      end
   end

   always_comb begin
      pop_pc    = '0;
      pop_instr = INST_W'(c_NOP_WORD);
      pop_exc   = 1'b0;
      if (!w_empty) begin
         pop_pc    = pc_mem_q[w_rd_idx];
         pop_instr = instr_mem_q[w_rd_idx];
         pop_exc   = exc_mem_q[w_rd_idx];
      end
   end

   a_count_range : assert property (@(posedge clk) disable iff (rst) count <= c_DEPTH);
   a_no_x_out    : assert property (@(posedge clk) disable iff (rst)
                                    !$isunknown({pop_valid, pop_pc, pop_instr, pop_exc}));

endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
// ============================================================================
// Module  : tb_inst_queue
// Brief   : Directed self-checking bench for inst_queue.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inst_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        push_valid = 1'b0;
   logic        push_ready;
   logic [31:0] push_pc = '0;
   logic [31:0] push_instr = '0;
   logic        push_exc = 1'b0;
   logic        pop_valid;
   logic        pop_ready = 1'b0;
   logic [31:0] pop_pc;
   logic [31:0] pop_instr;
   logic        pop_exc;
   logic [3:0]  count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   inst_queue #(.DEPTH(8), .PC_W(32), .INST_W(32)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .push_valid (push_valid),
      .push_ready (push_ready),
      .push_pc    (push_pc),
      .push_instr (push_instr),
      .push_exc   (push_exc),
      .pop_valid  (pop_valid),
      .pop_ready  (pop_ready),
      .pop_pc     (pop_pc),
      .pop_instr  (pop_instr),
      .pop_exc    (pop_exc),
      .count      (count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [31:0] pc, input logic [31:0] ins, input logic exc);
      push_valid = 1'b1;
      push_pc    = pc;
      push_instr = ins;
      push_exc   = exc;
      tick();
      push_valid = 1'b0;
      push_exc   = 1'b0;
   endtask

   initial begin
      // 1: reset
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("rst_push_ready", 64'(push_ready), 64'd1);
      chk("rst_pop_valid",  64'(pop_valid),  64'd0);
      chk("rst_count",      64'(count),      64'd0);
      chk("rst_pop_instr",  64'(pop_instr),  64'h0);
      chk("rst_pop_pc",     64'(pop_pc),     64'h0);

      // 2: single entry latency and pop
      push1(32'hBFC0_0000, 32'h3C08_BFC0, 1'b0);
      chk("one_valid", 64'(pop_valid), 64'd1);
      chk("one_pc",    64'(pop_pc),    64'hBFC0_0000);
      chk("one_instr", 64'(pop_instr), 64'h3C08_BFC0);
      chk("one_count", 64'(count),     64'd1);
      pop_ready = 1'b1;
      tick();
      pop_ready = 1'b0;
      chk("one_pop_count", 64'(count),     64'd0);
      chk("one_pop_instr", 64'(pop_instr), 64'h0);
      chk("one_pop_valid", 64'(pop_valid), 64'd0);

      // 3: fill, overflow attempt, full+pop, drain; then a second pass across the wrap
      for (int i = 0; i < 8; i++) push1(32'h100 + 32'(4*i), 32'h2400_0000 + 32'(i), 1'b0);
      chk("full_count", 64'(count),      64'd8);
      chk("full_ready", 64'(push_ready), 64'd0);
      push1(32'h999, 32'hFFFF_FFFF, 1'b0);
      chk("ovf_count", 64'(count), 64'd8);
      chk("head_pc",   64'(pop_pc), 64'h100);
      push_valid = 1'b1; push_pc = 32'h888; push_instr = 32'h8888_8888;
      pop_ready  = 1'b1;
      chk("full_pop_ready", 64'(push_ready), 64'd0);
      tick();
      push_valid = 1'b0;
      chk("full_pop_count", 64'(count), 64'd7);
      for (int i = 1; i < 8; i++) begin
         chk("drain_pc",    64'(pop_pc),    64'(32'h100 + 32'(4*i)));
         chk("drain_instr", 64'(pop_instr), 64'(32'h2400_0000 + 32'(i)));
         tick();
      end
      pop_ready = 1'b0;
      chk("drain_empty", 64'(pop_valid), 64'd0);
      for (int i = 0; i < 8; i++) push1(32'h300 + 32'(4*i), 32'h1000 + 32'(i), 1'b0);
      chk("wrap_full", 64'(push_ready), 64'd0);
      chk("wrap_count", 64'(count), 64'd8);
      pop_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("wrap_pc", 64'(pop_pc), 64'(32'h300 + 32'(4*i)));
         tick();
      end
      pop_ready = 1'b0;
      chk("wrap_count0", 64'(count), 64'd0);

      // 4: steady-state push & pop at occupancy 4
      for (int i = 0; i < 4; i++) push1(32'h400 + 32'(4*i), 32'(i), 1'b0);
      push_valid = 1'b1;
      pop_ready  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         push_pc    = 32'h400 + 32'(4*(k+4));
         push_instr = 32'(k+4);
         chk("ss_pc", 64'(pop_pc), 64'(32'h400 + 32'(4*k)));
         tick();
         chk("ss_count", 64'(count), 64'd4);
      end
      push_valid = 1'b0;
      for (int k = 20; k < 24; k++) begin
         chk("ss_tail_pc", 64'(pop_pc), 64'(32'h400 + 32'(4*k)));
         tick();
      end
      pop_ready = 1'b0;
      chk("ss_empty", 64'(count), 64'd0);

      // 5: flush with concurrent push and pop
      for (int i = 0; i < 5; i++) push1(32'h500 + 32'(4*i), 32'(i), 1'b0);
      chk("pre_flush_count", 64'(count), 64'd5);
      flush = 1'b1; push_valid = 1'b1; push_pc = 32'hDEAD; push_instr = 32'hDEAD; pop_ready = 1'b1;
      tick();
      flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
      chk("flush_count", 64'(count),     64'd0);
      chk("flush_valid", 64'(pop_valid), 64'd0);
      chk("flush_pc",    64'(pop_pc),    64'h0);
      push1(32'h200, 32'h0000_0020, 1'b0);
      chk("post_flush_pc",    64'(pop_pc), 64'h200);
      chk("post_flush_count", 64'(count),  64'd1);
      pop_ready = 1'b1;
      tick();
      pop_ready = 1'b0;

      // 6: exception flag follows its entry; reset mid-fill
      for (int i = 0; i < 8; i++) push1(32'h600 + 32'(4*i), 32'(i), (i == 0));
      pop_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("exc_flag", 64'(pop_exc), 64'(i == 0));
         tick();
      end
      pop_ready = 1'b0;
      for (int i = 0; i < 3; i++) push1(32'h700 + 32'(4*i), 32'(i), 1'b0);
      chk("mid_count", 64'(count), 64'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_count", 64'(count),      64'd0);
      chk("mid_rst_valid", 64'(pop_valid),  64'd0);
      chk("mid_rst_ready", 64'(push_ready), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
